// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: bus widths, fetch FSM encoding, PC step.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned INSTR_W = 16;

    // Byte-addressed 16-bit instruction words.
    localparam int unsigned PC_STEP = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_plus2.sv
// Sequential PC incrementer (PC + PC_STEP), wraps modulo 2^ADDR_W.
// Latency: combinational.
// Backpressure: none.
// Ports: pc_i current PC, pc_o next sequential PC.
module pc_plus2
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0] pc_i,
    output logic [ADDR_W-1:0] pc_o
);

    // Carry out of the top bit is simply dropped: FFFE + 2 = 0000.
    assign pc_o = pc_i + ADDR_W'(PC_STEP);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register + single-outstanding instruction fetch sequencer with a one-entry output buffer.
// Latency: MemAck -> InstrValid 1 cycle; DecReady handshake -> next MemReq 1 cycle.
// Backpressure: DecReady=0 parks the word in HOLD; no new fetch is issued until it is taken.
// Ports: Clock/ResetN (sync, active-low); MemReq/MemAddr/MemAck/MemData to instruction memory;
//        BranchTaken/BranchTarget redirect; Halt stop request; Instr/InstrPC/InstrValid/DecReady
//        to decoder; PC current PC; Halted in HALT state.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic               Clock,
    input  logic               ResetN,
    output logic               MemReq,
    output logic [ADDR_W-1:0]  MemAddr,
    input  logic               MemAck,
    input  logic [INSTR_W-1:0] MemData,
    input  logic               BranchTaken,
    input  logic [ADDR_W-1:0]  BranchTarget,
    input  logic               Halt,
    input  logic               DecReady,
    output logic [INSTR_W-1:0] Instr,
    output logic [ADDR_W-1:0]  InstrPC,
    output logic               InstrValid,
    output logic [ADDR_W-1:0]  PC,
    output logic               Halted
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               mem_req_q, mem_req_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               instr_vld_q, instr_vld_d;
    logic               halted_q, halted_d;
    logic               redir_pend_q, redir_pend_d;
    logic [ADDR_W-1:0]  redir_tgt_q, redir_tgt_d;

    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  branch_tgt;

    pc_plus2 u_pc_plus2 (
        .pc_i (pc_q),
        .pc_o (pc_inc)
    );

    // Instructions are word aligned, so the target LSB is cleared rather than trusted.
    assign branch_tgt = BranchTarget & ~ADDR_W'(1);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        instr_vld_d  = instr_vld_q;
        redir_pend_d = redir_pend_q;
        redir_tgt_d  = redir_tgt_q;

        case (state_q)
            IDLE: begin
                if (BranchTaken) begin
                    pc_d = branch_tgt;
                end
                state_d = Halt ? HALT : FETCH;
            end

            FETCH: begin
                if (MemAck) begin
                    if (BranchTaken) begin
                        // Word belongs to the wrong path: drop it and refetch at the target.
                        pc_d         = branch_tgt;
                        redir_pend_d = 1'b0;
                    end else if (redir_pend_q) begin
                        // Request was already committed when the redirect arrived; its data is stale.
                        pc_d         = redir_tgt_q;
                        redir_pend_d = 1'b0;
                    end else begin
                        instr_d     = MemData;
                        instr_pc_d  = pc_q;
                        instr_vld_d = 1'b1;
                        pc_d        = pc_inc;
                        state_d     = HOLD;
                    end
                end else if (BranchTaken) begin
                    // Address must stay stable until ack, so park the target; latest redirect wins.
                    redir_pend_d = 1'b1;
                    redir_tgt_d  = branch_tgt;
                end
            end

            HOLD: begin
                if (BranchTaken) begin
                    // Flush takes priority over a same-cycle decoder accept.
                    instr_vld_d = 1'b0;
                    pc_d        = branch_tgt;
                    state_d     = FETCH;
                end else if (DecReady) begin
                    instr_vld_d = 1'b0;
                    state_d     = Halt ? HALT : FETCH;
                end
            end

            HALT: begin
                // Terminal until reset; redirects are ignored.
                instr_vld_d = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        mem_req_d = (state_d == FETCH);
        halted_d  = (state_d == HALT);
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            mem_req_q    <= 1'b0;
            instr_q      <= '0;
            instr_pc_q   <= '0;
            instr_vld_q  <= 1'b0;
            halted_q     <= 1'b0;
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mem_req_q    <= mem_req_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            instr_vld_q  <= instr_vld_d;
            halted_q     <= halted_d;
            redir_pend_q <= redir_pend_d;
            redir_tgt_q  <= redir_tgt_d;
        end
    end

    assign MemReq     = mem_req_q;
    assign MemAddr    = pc_q;
    assign Instr      = instr_q;
    assign InstrPC    = instr_pc_q;
    assign InstrValid = instr_vld_q;
    assign PC         = pc_q;
    assign Halted     = halted_q;

endmodule
